ladybug_dl_ctrl: RTL and testbench



---
 rtl/ladybug_pkg.sv | 14 +
 rtl/reset_stretch.sv | 36 +++
 rtl/ladybug_dl_ctrl.sv | 125 ++++++++++++
 tb/tb_ladybug_dl_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybug_pkg.sv
// Shared types and defaults for the ladybug download sequencer.
package ladybug_pkg;

  typedef enum logic [1:0] {
    StNoRom,
    StLoad,
    StHold,
    StRun
  } dl_state_t;

  localparam int unsigned ROM_SIZE_DEF    = 65536;
  localparam int unsigned HOLD_CYCLES_DEF = 1024;

endpackage

// File: rtl/reset_stretch.sv
// Loadable down-counter timing the core-reset stretch; expired is high once the count hits zero.
module reset_stretch #(
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES);
  localparam logic [CntW-1:0] LoadVal = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = LoadVal;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ladybug_dl_ctrl.sv
// Forwards HPS download bytes into the ladybug core, checks the image and owns the core reset.
module ladybug_dl_ctrl
  import ladybug_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = ROM_SIZE_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        rst_req,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        rom_ready,
  output logic        dl_error,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum
);

  localparam logic [24:0] RomLimit = 25'(ROM_SIZE);
  localparam logic [16:0] RomCount = 17'(ROM_SIZE);

  dl_state_t   state_q, state_d;
  logic        dl_prev_q, oob_q, oob_next;
  logic        dn_wr_q, core_reset_q, rom_ready_q, dl_error_q;
  logic [15:0] dn_addr_q;
  logic [7:0]  dn_data_q, checksum_q;
  logic [16:0] byte_count_q, count_inc, count_next;
  logic        dl_rise, in_load, accept, oob_hit, good_load;
  logic        enter_load, hold_restart, hold_expired;

  assign dl_rise = ioctl_download & ~dl_prev_q;
  assign in_load = (state_q == StLoad);
  assign accept  = in_load & ioctl_wr & (ioctl_addr < RomLimit);
  assign oob_hit = in_load & ioctl_wr & (ioctl_addr >= RomLimit);

  assign count_inc  = (byte_count_q == RomCount) ? byte_count_q : byte_count_q + 17'd1;
  assign count_next = accept ? count_inc : byte_count_q;
  assign oob_next   = oob_q | oob_hit;
  // A strobe landing with the falling download is counted before completeness is judged.
  assign good_load  = (count_next == RomCount) & ~oob_next;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNoRom: if (ioctl_download) state_d = StLoad;
      StLoad:  if (!ioctl_download) state_d = good_load ? StHold : StNoRom;
      StHold:  if (hold_expired && !rst_req) state_d = StRun;
      StRun:   if (rst_req) state_d = StHold;
      default: state_d = StNoRom;
    endcase
    if (dl_rise) state_d = StLoad;
  end

  assign enter_load   = (state_d == StLoad) && (state_q != StLoad);
  // rst_req held in HOLD keeps reloading the stretch.
  assign hold_restart = (state_d == StHold) && ((state_q != StHold) || rst_req);

  reset_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_reset_stretch (
    .clk    (clk_sys),
    .reset  (reset),
    .restart(hold_restart),
    .enable (state_q == StHold),
    .expired(hold_expired)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StNoRom;
      dl_prev_q    <= 1'b0;
      oob_q        <= 1'b0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      core_reset_q <= 1'b1;
      rom_ready_q  <= 1'b0;
      dl_error_q   <= 1'b0;
      byte_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= ioctl_download;
      dn_wr_q      <= accept;
      core_reset_q <= (state_d != StRun);
      if (accept) begin
        dn_addr_q <= ioctl_addr[15:0];
        dn_data_q <= ioctl_dout;
      end
      if (enter_load) begin
        byte_count_q <= '0;
        checksum_q   <= '0;
        oob_q        <= 1'b0;
        dl_error_q   <= 1'b0;
        rom_ready_q  <= 1'b0;
      end else begin
        byte_count_q <= count_next;
        checksum_q   <= accept ? checksum_q + ioctl_dout : checksum_q;
        oob_q        <= oob_next;
        if (in_load && (state_d == StNoRom)) begin
          dl_error_q  <= 1'b1;
          rom_ready_q <= 1'b0;
        end else if (in_load && (state_d == StHold)) begin
          rom_ready_q <= 1'b1;
        end
      end
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign core_reset = core_reset_q;
  assign rom_ready  = rom_ready_q;
  assign dl_error   = dl_error_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_ladybug_dl_ctrl.sv
// Directed scenario bench for ladybug_dl_ctrl with a 16-byte image and an 8-cycle hold.
module tb_ladybug_dl_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        rst_req = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        rom_ready;
  logic        dl_error;
  logic [16:0] byte_count;
  logic [7:0]  checksum;

  int total = 0;
  int bad = 0;

  always #5 clk_sys = ~clk_sys;

  ladybug_dl_ctrl #(
    .ROM_SIZE   (16),
    .HOLD_CYCLES(8)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .rst_req       (rst_req),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .core_reset    (core_reset),
    .rom_ready     (rom_ready),
    .dl_error      (dl_error),
    .byte_count    (byte_count),
    .checksum      (checksum)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One-cycle strobe; returns just after the edge that registers it.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic drop);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (drop) ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({core_reset, rom_ready, dl_error, dn_wr} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got %b want 1000", {core_reset, rom_ready, dl_error, dn_wr});
    end
    total++;
    if ({dn_addr, dn_data, byte_count, checksum} !== 49'd0) begin
      bad++;
      $display("FAIL reset_values got %h/%h/%h/%h want 0", dn_addr, dn_data, byte_count,
               checksum);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd3;
        ioctl_dout = 8'h55;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
      total++;
      if ({core_reset, rom_ready, dn_wr, byte_count} !== {3'b100, 17'd0}) begin
        bad++;
        $display("FAIL idle cyc%0d got cr=%b rr=%b wr=%b bc=%0d want cr=1 rr=0 wr=0 bc=0", i,
                 core_reset, rom_ready, dn_wr, byte_count);
      end
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic test_full_load();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      send_byte(25'(i), 8'(i + 1), 1'b0);
      total++;
      if ({dn_wr, dn_addr, dn_data} !== {1'b1, 16'(i), 8'(i + 1)}) begin
        bad++;
        $display("FAIL full_byte%0d got wr=%b a=%h d=%h want wr=1 a=%h d=%h", i, dn_wr, dn_addr,
                 dn_data, 16'(i), 8'(i + 1));
      end
    end
    ioctl_download = 1'b0;
    tick();
    total++;
    if ({dn_wr, rom_ready, dl_error, core_reset, byte_count, checksum} !==
        {4'b0101, 17'd16, 8'h88}) begin
      bad++;
      $display("FAIL full_end got wr=%b rr=%b err=%b cr=%b bc=%0d cs=%h want 0 1 0 1 16 88",
               dn_wr, rom_ready, dl_error, core_reset, byte_count, checksum);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if (core_reset !== 1'b1) begin
        bad++;
        $display("FAIL full_hold%0d got cr=%b want 1", i, core_reset);
      end
    end
    tick();
    total++;
    if ({core_reset, rom_ready} !== 2'b01) begin
      bad++;
      $display("FAIL full_run got cr=%b rr=%b want cr=0 rr=1", core_reset, rom_ready);
    end
  endtask

  task automatic test_rst_req();
    rst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({core_reset, rom_ready} !== 2'b11) begin
        bad++;
        $display("FAIL rstreq_high%0d got cr=%b rr=%b want 1 1", i, core_reset, rom_ready);
      end
    end
    rst_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if ({core_reset, rom_ready} !== 2'b11) begin
        bad++;
        $display("FAIL rstreq_hold%0d got cr=%b rr=%b want 1 1", i, core_reset, rom_ready);
      end
    end
    tick();
    total++;
    if ({core_reset, rom_ready} !== 2'b01) begin
      bad++;
      $display("FAIL rstreq_run got cr=%b rr=%b want 0 1", core_reset, rom_ready);
    end
    // Strobes outside LOAD must be ignored.
    send_byte(25'd2, 8'h77, 1'b0);
    total++;
    if ({dn_wr, byte_count} !== {1'b0, 17'd16}) begin
      bad++;
      $display("FAIL run_ignore got wr=%b bc=%0d want 0 16", dn_wr, byte_count);
    end
  endtask

  task automatic test_short_load();
    ioctl_download = 1'b1;
    tick();
    total++;
    if ({core_reset, rom_ready, byte_count, checksum} !== {2'b10, 17'd0, 8'h00}) begin
      bad++;
      $display("FAIL short_start got cr=%b rr=%b bc=%0d cs=%h want 1 0 0 00", core_reset,
               rom_ready, byte_count, checksum);
    end
    for (int i = 0; i < 10; i++) send_byte(25'(i), 8'(8'h20 + i), 1'b0);
    ioctl_download = 1'b0;
    tick();
    total++;
    if ({dl_error, rom_ready, core_reset, byte_count, checksum} !== {3'b101, 17'd10, 8'h6D}) begin
      bad++;
      $display("FAIL short_end got err=%b rr=%b cr=%b bc=%0d cs=%h want 1 0 1 10 6d", dl_error,
               rom_ready, core_reset, byte_count, checksum);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if ({core_reset, dl_error} !== 2'b11) begin
        bad++;
        $display("FAIL short_stay%0d got cr=%b err=%b want 1 1", i, core_reset, dl_error);
      end
    end
  endtask

  task automatic test_oob();
    ioctl_download = 1'b1;
    tick();
    total++;
    if (dl_error !== 1'b0) begin
      bad++;
      $display("FAIL oob_clear got err=%b want 0", dl_error);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        send_byte(25'd16, 8'hAA, 1'b0);
        total++;
        if (dn_wr !== 1'b0) begin
          bad++;
          $display("FAIL oob_nowr got wr=%b want 0", dn_wr);
        end
      end
      send_byte(25'(i), 8'(i + 1), 1'b0);
    end
    ioctl_download = 1'b0;
    tick();
    total++;
    if ({dl_error, rom_ready, core_reset, byte_count, checksum} !== {3'b101, 17'd16, 8'h88}) begin
      bad++;
      $display("FAIL oob_end got err=%b rr=%b cr=%b bc=%0d cs=%h want 1 0 1 16 88", dl_error,
               rom_ready, core_reset, byte_count, checksum);
    end
  endtask

  task automatic test_async_reset();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send_byte(25'(i), 8'(8'h40 + i), 1'b0);
    #2;
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    total++;
    if ({core_reset, rom_ready, dl_error, dn_wr} !== 4'b1000) begin
      bad++;
      $display("FAIL areset_flags got %b want 1000", {core_reset, rom_ready, dl_error, dn_wr});
    end
    total++;
    if ({dn_addr, dn_data, byte_count, checksum} !== 49'd0) begin
      bad++;
      $display("FAIL areset_values got %h/%h/%h/%h want 0", dn_addr, dn_data, byte_count,
               checksum);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      send_byte(25'(i), 8'(8'hF0 + i), (i == 15));
      total++;
      if ({dn_wr, dn_addr, dn_data} !== {1'b1, 16'(i), 8'(8'hF0 + i)}) begin
        bad++;
        $display("FAIL b2b_byte%0d got wr=%b a=%h d=%h want wr=1 a=%h d=%h", i, dn_wr, dn_addr,
                 dn_data, 16'(i), 8'(8'hF0 + i));
      end
    end
    total++;
    if ({rom_ready, dl_error, core_reset, byte_count, checksum} !== {3'b101, 17'd16, 8'h78}) begin
      bad++;
      $display("FAIL b2b_end got rr=%b err=%b cr=%b bc=%0d cs=%h want 1 0 1 16 78", rom_ready,
               dl_error, core_reset, byte_count, checksum);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if ({core_reset, dn_wr} !== 2'b10) begin
        bad++;
        $display("FAIL b2b_hold%0d got cr=%b wr=%b want 1 0", i, core_reset, dn_wr);
      end
    end
    tick();
    total++;
    if ({core_reset, rom_ready} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_run got cr=%b rr=%b want 0 1", core_reset, rom_ready);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_load();
    test_rst_req();
    test_short_load();
    test_oob();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
